// File: rtl/package_settings.sv
// Project-wide data-path widths shared by the filter chain.
package package_settings;
  localparam int unsigned SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/peak_ctrl_parameters.sv
// Shared types and defaults for the peak detection controller.
package peak_ctrl_parameters;
  localparam int unsigned SIZE_TS           = 32;
  localparam int unsigned DEAD_TIME_DEFAULT = 16;
  localparam int unsigned MAX_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ABOVE = 2'd2,
    DEAD  = 2'd3
  } peak_state_e;
endpackage

// File: rtl/peak_ts_counter.sv
// Free-running timestamp counter; wraps silently to zero.
module peak_ts_counter
  import peak_ctrl_parameters::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [SIZE_TS-1:0] count
);
  logic [SIZE_TS-1:0] count_q, count_d;

  always_comb count_d = count_q + SIZE_TS'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/filter_peak_ctrl.sv
// Threshold-triggered peak capture with dead-time, pile-up limit and a
// single-entry holding register with valid/ready handoff.
module filter_peak_ctrl
  import package_settings::*;
  import peak_ctrl_parameters::*;
#(
  parameter int unsigned DEAD_TIME = DEAD_TIME_DEFAULT,
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic                               enable,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_data,
  output logic        [SIZE_TS-1:0]          peak_time,
  output logic                               peak_pileup,
  output logic                               peak_valid,
  input  logic                               peak_ready,
  output logic        [15:0]                 lost_count,
  output logic                               busy
);
  localparam logic [7:0] DEAD_INIT = 8'(DEAD_TIME);
  localparam logic [7:0] MAX_W     = 8'(MAX_WIDTH);

  logic [SIZE_TS-1:0] ts;

  peak_ts_counter u_ts (
    .clk   (clk),
    .reset (reset),
    .count (ts)
  );

  peak_state_e                        state_q, state_d;
  logic signed [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic        [SIZE_TS-1:0]          max_t_q, max_t_d;
  logic        [7:0]                  width_q, width_d;
  logic        [7:0]                  dead_q, dead_d;
  logic signed [SIZE_FILTER_DATA-1:0] peak_data_q, peak_data_d;
  logic        [SIZE_TS-1:0]          peak_time_q, peak_time_d;
  logic                               peak_pileup_q, peak_pileup_d;
  logic                               peak_valid_q, peak_valid_d;
  logic        [15:0]                 lost_q, lost_d;
  logic                               above, emit, emit_pileup, handshake;

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    max_t_d     = max_t_q;
    width_d     = width_q;
    dead_d      = dead_q;
    emit        = 1'b0;
    emit_pileup = 1'b0;
    above       = filter_data > threshold;

    case (state_q)
      IDLE:  state_d = ARMED;
      ARMED: begin
        if (above) begin
          state_d = ABOVE;
          max_d   = filter_data;
          max_t_d = ts;
          width_d = 8'd1;
        end
      end
      ABOVE: begin
        if (!above) begin
          emit    = 1'b1;
          state_d = DEAD;
          dead_d  = DEAD_INIT;
        end else if (width_q == MAX_W) begin
          emit        = 1'b1;
          emit_pileup = 1'b1;
          state_d     = DEAD;
          dead_d      = DEAD_INIT;
        end else begin
          width_d = width_q + 8'd1;
          // Strict compare: a plateau keeps the time of its first sample.
          if (filter_data > max_q) begin
            max_d   = filter_data;
            max_t_d = ts;
          end
        end
      end
      DEAD: begin
        if (dead_q == 8'd0 && !above) state_d = ARMED;
        else if (dead_q != 8'd0)      dead_d  = dead_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything, including a pulse about to close.
    if (!enable) begin
      state_d     = IDLE;
      emit        = 1'b0;
      emit_pileup = 1'b0;
    end
  end

  always_comb begin
    peak_data_d   = peak_data_q;
    peak_time_d   = peak_time_q;
    peak_pileup_d = peak_pileup_q;
    peak_valid_d  = peak_valid_q;
    lost_d        = lost_q;
    handshake     = peak_valid_q & peak_ready;

    if (emit && (!peak_valid_q || handshake)) begin
      peak_data_d   = max_q;
      peak_time_d   = max_t_q;
      peak_pileup_d = emit_pileup;
      peak_valid_d  = 1'b1;
    end else if (emit) begin
      if (lost_q != '1) lost_d = lost_q + 16'd1;
    end else if (handshake) begin
      peak_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      max_q         <= '0;
      max_t_q       <= '0;
      width_q       <= '0;
      dead_q        <= '0;
      peak_data_q   <= '0;
      peak_time_q   <= '0;
      peak_pileup_q <= 1'b0;
      peak_valid_q  <= 1'b0;
      lost_q        <= '0;
    end else begin
      state_q       <= state_d;
      max_q         <= max_d;
      max_t_q       <= max_t_d;
      width_q       <= width_d;
      dead_q        <= dead_d;
      peak_data_q   <= peak_data_d;
      peak_time_q   <= peak_time_d;
      peak_pileup_q <= peak_pileup_d;
      peak_valid_q  <= peak_valid_d;
      lost_q        <= lost_d;
    end
  end

  assign peak_data   = peak_data_q;
  assign peak_time   = peak_time_q;
  assign peak_pileup = peak_pileup_q;
  assign peak_valid  = peak_valid_q;
  assign lost_count  = lost_q;
  assign busy        = (state_q == ABOVE) || (state_q == DEAD);
endmodule

// File: tb/tb_filter_peak_ctrl.sv
// Bench for filter_peak_ctrl: directed vector table, corner sequences and
// randomized traffic against a pulse-list reference model.
module tb_filter_peak_ctrl;
  import package_settings::*;

  localparam int DT = 5;
  localparam int MW = 4;
  localparam int W  = SIZE_FILTER_DATA;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic signed [W-1:0] filter_data = '0;
  logic signed [W-1:0] threshold = 16'sd100;
  logic                enable = 1'b0;
  logic                peak_ready = 1'b0;
  logic signed [W-1:0] peak_data;
  logic [31:0]         peak_time;
  logic                peak_pileup, peak_valid, busy;
  logic [15:0]         lost_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  filter_peak_ctrl #(.DEAD_TIME(DT), .MAX_WIDTH(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .filter_data (filter_data),
    .enable      (enable),
    .threshold   (threshold),
    .peak_data   (peak_data),
    .peak_time   (peak_time),
    .peak_pileup (peak_pileup),
    .peak_valid  (peak_valid),
    .peak_ready  (peak_ready),
    .lost_count  (lost_count),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pulse is the list of its above-threshold samples;
  // the reported peak is the first largest entry of that list.
  typedef struct { logic signed [W-1:0] d; logic [31:0] t; } samp_t;
  samp_t               pulse[$];
  int                  m_mode;      // 0 idle, 1 waiting, 2 in pulse, 3 hold-off
  int                  m_hold_left;
  logic [31:0]         m_ts;
  logic                m_valid, m_pile;
  logic signed [W-1:0] m_data;
  logic [31:0]         m_time;
  int                  m_lost;

  task automatic model_reset();
    pulse.delete();
    m_mode = 0; m_hold_left = 0; m_ts = 0;
    m_valid = 0; m_pile = 0; m_data = 0; m_time = 0; m_lost = 0;
  endtask

  task automatic model_step(input logic signed [W-1:0] d, input logic signed [W-1:0] thr,
                            input logic en, input logic rdy);
    bit fire, pile, take;
    int best;
    fire = 0; pile = 0;
    take = m_valid && rdy;
    if (!en) begin
      m_mode = 0;
      pulse.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (d > thr) begin
        pulse.delete();
        pulse.push_back('{d, m_ts});
        m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (d <= thr) fire = 1;
      else if (pulse.size() == MW) begin fire = 1; pile = 1; end
      else pulse.push_back('{d, m_ts});
    end else begin
      if (m_hold_left == 0 && d <= thr) m_mode = 1;
      else if (m_hold_left > 0) m_hold_left--;
    end
    if (fire) begin
      best = 0;
      for (int i = 1; i < pulse.size(); i++)
        if (pulse[i].d > pulse[best].d) best = i;
      m_mode = 3;
      m_hold_left = DT;
      if (!m_valid || take) begin
        m_valid = 1; m_data = pulse[best].d; m_time = pulse[best].t; m_pile = pile;
      end else if (m_lost < 65535) m_lost++;
      pulse.delete();
    end else if (take) begin
      m_valid = 0;
    end
    m_ts = m_ts + 32'd1;
  endtask

  task automatic compare_model();
    chk("valid", peak_valid, m_valid);
    chk("lost", lost_count, 64'(m_lost));
    chk("busy", busy, (m_mode == 2 || m_mode == 3));
    if (m_valid) begin
      chk("data", peak_data, m_data);
      chk("time", peak_time, m_time);
      chk("pileup", peak_pileup, m_pile);
    end
  endtask

  task automatic cycle(input int d, input int thr, input logic en, input logic rdy);
    filter_data = W'(d);
    threshold   = W'(thr);
    enable      = en;
    peak_ready  = rdy;
    @(posedge clk);
    model_step(filter_data, threshold, en, rdy);
    @(negedge clk);
    compare_model();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_data"}, peak_data, 0);
    chk({name, "_time"}, peak_time, 0);
    chk({name, "_pileup"}, peak_pileup, 0);
    chk({name, "_valid"}, peak_valid, 0);
    chk({name, "_lost"}, lost_count, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  typedef struct {
    int   d;
    logic rdy;
    logic e_valid;
    logic e_busy;
    logic chk_pk;
    int   e_data;
    int   e_time;
  } vec_t;
  vec_t tab[17];

  initial begin
    logic [31:0] t_first;

    for (int i = 0; i < 17; i++) tab[i] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tab[11].d = 50;
    tab[12] = '{120, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    tab[13] = '{200, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    tab[14] = '{180, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    tab[15] = '{90,  1'b0, 1'b1, 1'b1, 1'b1, 200, 13};
    tab[16] = '{0,   1'b1, 1'b0, 1'b1, 1'b1, 200, 13};

    model_reset();
    #1 chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Basic pulse: samples at ts 10..15
    for (int i = 0; i < 17; i++) begin
      cycle(tab[i].d, 100, 1'b1, tab[i].rdy);
      chk("vec_valid", peak_valid, tab[i].e_valid);
      chk("vec_busy", busy, tab[i].e_busy);
      if (tab[i].chk_pk) begin
        chk("vec_data", peak_data, 64'(tab[i].e_data));
        chk("vec_time", peak_time, 64'(tab[i].e_time));
        chk("vec_pileup", peak_pileup, 0);
      end
    end

    // Plateau keeps time of first equal maximum
    for (int i = 0; i < DT + 3; i++) cycle(0, 100, 1'b1, 1'b0);
    t_first = m_ts;
    cycle(150, 100, 1'b1, 1'b0);
    cycle(150, 100, 1'b1, 1'b0);
    cycle(150, 100, 1'b1, 1'b0);
    cycle(0, 100, 1'b1, 1'b0);
    chk("plateau_valid", peak_valid, 1);
    chk("plateau_data", peak_data, 150);
    chk("plateau_time", peak_time, t_first);
    cycle(0, 100, 1'b1, 1'b1);

    // Pile-up: constant 300 closes after MW samples, no rearm while high
    for (int i = 0; i < DT + 3; i++) cycle(0, 100, 1'b1, 1'b0);
    for (int i = 0; i < MW + 1; i++) cycle(300, 100, 1'b1, 1'b0);
    chk("pile_valid", peak_valid, 1);
    chk("pile_flag", peak_pileup, 1);
    chk("pile_data", peak_data, 300);
    for (int i = 0; i < DT + 4; i++) cycle(300, 100, 1'b1, 1'b0);
    chk("pile_no_rearm", busy, 1);
    cycle(0, 100, 1'b1, 1'b0);
    chk("pile_rearm", busy, 0);
    cycle(0, 100, 1'b1, 1'b1);

    // Three pulses with consumer stalled
    for (int p = 0; p < 3; p++) begin
      cycle(200 + p, 100, 1'b1, 1'b0);
      cycle(200 + p, 100, 1'b1, 1'b0);
      for (int i = 0; i < DT + 3; i++) cycle(0, 100, 1'b1, 1'b0);
    end
    chk("stall_lost", lost_count, 2);
    chk("stall_held", peak_data, 200);
    cycle(0, 100, 1'b1, 1'b1);
    chk("stall_clear", peak_valid, 0);
    chk("stall_lost_keep", lost_count, 2);

    // Enable dropped mid-pulse
    cycle(250, 100, 1'b1, 1'b0);
    chk("endrop_above", busy, 1);
    cycle(250, 100, 1'b0, 1'b0);
    chk("endrop_idle", busy, 0);
    chk("endrop_noevt", peak_valid, 0);
    for (int i = 0; i < 3; i++) cycle(0, 100, 1'b1, 1'b0);
    chk("endrop_noevt2", peak_valid, 0);

    // Asynchronous reset during dead time
    cycle(220, 100, 1'b1, 1'b0);
    cycle(0, 100, 1'b1, 1'b0);
    chk("dead_valid", peak_valid, 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Timestamp wrap
    cycle(0, 100, 1'b1, 1'b0);
    cycle(0, 100, 1'b1, 1'b0);
    force dut.u_ts.count_q = 32'hFFFF_FFFE;
    #1 release dut.u_ts.count_q;
    m_ts = 32'hFFFF_FFFE;
    cycle(150, 100, 1'b1, 1'b0);
    cycle(120, 100, 1'b1, 1'b0);
    cycle(250, 100, 1'b1, 1'b0);
    cycle(0, 100, 1'b1, 1'b0);
    chk("wrap_data", peak_data, 250);
    chk("wrap_time", peak_time, 0);
    cycle(0, 100, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int d, thr;
      logic en, rdy;
      d   = int'($urandom_range(0, 350)) - 60;
      thr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 170)) - 20 : 100;
      en  = ($urandom_range(0, 99) < 97);
      rdy = ($urandom_range(0, 3) == 0);
      cycle(d, thr, en, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/filter_peak_ctrl.md
FILTER_PEAK_CTRL -- requirements
Module: filter_peak_ctrl

Interface
REQ-001 SHALL have parameters: DEAD_TIME, default 16, post-pulse rearm hold-off in clocks (1..255); MAX_WIDTH, default 64, cycles above threshold before forced pile-up emit (2..255).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port filter_data  input  SIZE_FILTER_DATA  signed shaped sample from the filter, one per clock.
REQ-005 SHALL have port enable  input  1  1 = run detection, 0 = force IDLE.
REQ-006 SHALL have port threshold  input  SIZE_FILTER_DATA  signed trigger level, sampled every clock.
REQ-007 SHALL have port peak_data  output  SIZE_FILTER_DATA  maximum sample of the captured pulse.
REQ-008 SHALL have port peak_time  output  SIZE_TS  timestamp of that maximum.
REQ-009 SHALL have port peak_pileup  output  1  event closed by MAX_WIDTH, not by falling crossing.
REQ-010 SHALL have port peak_valid  output  1  event holding register full.
REQ-011 SHALL have port peak_ready  input  1  consumer accepts event when peak_valid & peak_ready.
REQ-012 SHALL have port lost_count  output  16  events dropped because holding register full.
REQ-013 SHALL have port busy  output  1  1 when state is ABOVE or DEAD.

Function
REQ-014 SHALL keep free-running SIZE_TS-bit timestamp ts, +1 per clock, wrapping to 0 silently.
REQ-015 SHALL implement FSM states IDLE, ARMED, ABOVE, DEAD; all compares signed.
REQ-016 IDLE -> ARMED on edge with enable=1.
REQ-017 ARMED: filter_data > threshold -> ABOVE; max <= filter_data, max_t <= ts, width <= 1.
REQ-018 ABOVE: filter_data > max -> max, max_t updated (equal sample keeps earlier time); width +1.
REQ-019 ABOVE: filter_data <= threshold -> emit event (pileup=0), DEAD, dead counter <= DEAD_TIME.
REQ-020 ABOVE: width == MAX_WIDTH with sample still above threshold -> emit event (pileup=1), DEAD.
REQ-021 DEAD: decrement counter; leave to ARMED only when counter == 0 AND filter_data <= threshold, else stay (counter holds at 0).
REQ-022 enable=0 in any state -> IDLE next edge; open event in ABOVE discarded; holding register and lost_count untouched.
REQ-023 Emit: peak_data/peak_time/peak_pileup loaded and peak_valid set at the same edge that closes the pulse (1-clock latency from closing sample).
REQ-024 peak_valid SHALL stay 1 and outputs stable until handshake edge; handshake edge clears peak_valid.
REQ-025 Emit while peak_valid=1 and no handshake that edge -> event dropped, register unchanged, lost_count +1, saturating at 65535.
REQ-026 Emit on same edge as handshake -> new event loaded, peak_valid stays 1, no loss.
REQ-027 busy SHALL be combinational decode of state.

Reset
REQ-028 reset=0 SHALL asynchronously force: state IDLE, ts 0, max/max_t/width/dead counter 0, peak_data 0, peak_time 0, peak_pileup 0, peak_valid 0, lost_count 0, busy 0.
REQ-029 Reset mid-pulse SHALL discard the pulse; first ts after release is 0 at first active edge +1.

Structure
REQ-030 SIZE_FILTER_DATA SHALL come from package_settings; SIZE_TS (=32), state enum typedef, and DEAD_TIME/MAX_WIDTH defaults SHALL live in shared package peak_ctrl_parameters.
REQ-031 Timestamp counter SHALL be sub-module peak_ts_counter (clk, reset, count output); rest in filter_peak_ctrl.

Verification
REQ-032 threshold=100, enable=1, data 0,50,120,200,180,90 at ts 10..15 -> one event peak_data=200, peak_time=13, pileup=0, peak_valid from edge sampling 90.
REQ-033 Plateau 150,150,150 then 0 (threshold 100) -> peak_data=150, peak_time = ts of first 150.
REQ-034 MAX_WIDTH=4, data 300 constant -> event after 4 samples, pileup=1; no rearm until data <= threshold after DEAD_TIME clocks.
REQ-035 peak_ready=0, three separated pulses -> first held, lost_count=2; raising peak_ready one clock clears peak_valid.
REQ-036 enable dropped during ABOVE -> no event, IDLE next edge; reset=0 mid-DEAD -> all outputs 0 asynchronously.
REQ-037 Preload ts near 2^32-1 via long run or force -> wraps to 0, event captured across wrap reports raw wrapped value.
